l3_cache_assoc: RTL and testbench

//  Parametrised N-way set-associative, write-back, write-allocate last-level cache.

---
 rtl/l3_cache_pkg.sv | 41 ++++
 rtl/l3_plru.sv | 51 +++++
 rtl/l3_cache_assoc.sv | 233 +++++++++++++++++++++++
 tb/tb_l3_cache_assoc.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l3_cache_pkg.sv
// Shared types and tree pseudo-LRU helpers for the set-associative L3 cache.
// Tree bits are heap-ordered (node 1 = root); a bit of 1 means the right subtree is least recent.
package l3_cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE_BACK,
    FILL,
    INSTALL,
    RESPOND
  } state_t;

  // Supports up to 8 ways: 7 tree bits, 3 levels.
  function automatic logic [2:0] plru_victim(input logic [6:0] bits, input int unsigned levels);
    int unsigned node;
    logic [2:0]  way;
    node = 1;
    way  = '0;
    for (int unsigned l = 0; l < levels; l++) begin
      way  = {way[1:0], bits[3'(node - 1)]};
      node = 2 * node + (bits[3'(node - 1)] ? 1 : 0);
    end
    return way;
  endfunction

  function automatic logic [6:0] plru_touch(input logic [6:0] bits, input logic [2:0] way,
                                            input int unsigned levels);
    logic [6:0]  nb;
    int unsigned node;
    logic        dir;
    nb   = bits;
    node = 1;
    for (int unsigned l = 0; l < levels; l++) begin
      dir               = way[2'(levels - 1 - l)];
      nb[3'(node - 1)]  = ~dir;
      node              = 2 * node + (dir ? 1 : 0);
    end
    return nb;
  endfunction

endpackage

// File: rtl/l3_plru.sv
// Per-set tree pseudo-LRU state: WAYS-1 bits per set, touched on hits and installs.
module l3_plru
  import l3_cache_pkg::*;
#(
  parameter int unsigned SETS  = 64,
  parameter int unsigned WAYS  = 2,
  parameter int unsigned SET_W = 6,
  parameter int unsigned WAY_W = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             touch,
  input  logic [WAY_W-1:0] touch_way,
  input  logic [SET_W-1:0] set_idx,
  output logic [WAY_W-1:0] victim_way
);

  generate
    if (WAYS == 1) begin : g_direct
      assign victim_way = '0;
      logic unused_plru;
      assign unused_plru = ^{clk, reset, touch, touch_way, set_idx};
    end else begin : g_tree
      localparam int unsigned LEVELS = $clog2(WAYS);

      logic [WAYS-2:0] bits [SETS];
      logic [6:0]      cur;
      logic [6:0]      nxt_full;
      logic [2:0]      vic_full;
      logic            unused_plru_bits;

      always_comb begin
        cur      = 7'(bits[set_idx]);
        vic_full = plru_victim(cur, LEVELS);
        nxt_full = plru_touch(cur, 3'(touch_way), LEVELS);
      end

      assign victim_way       = vic_full[WAY_W-1:0];
      assign unused_plru_bits = ^{vic_full, nxt_full};

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int unsigned s = 0; s < SETS; s++) bits[s] <= '0;
        end else if (touch) begin
          bits[set_idx] <= nxt_full[WAYS-2:0];
        end
      end
    end
  endgenerate

endmodule

// File: rtl/l3_cache_assoc.sv
// N-way set-associative write-back/write-allocate last-level cache with
// tree PLRU replacement and a write-back-then-fill miss sequence.
module l3_cache_assoc
  import l3_cache_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SET_WIDTH  = 6,
  parameter int unsigned WAYS       = 2,
  parameter int unsigned LINE_SIZE  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [DATA_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] writeData,
  output logic [DATA_WIDTH-1:0] readData,
  output logic                  rsp_valid,
  output logic                  hit,
  output logic                  stall,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [DATA_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  input  logic                  mem_ready
);

  localparam int unsigned OFF_W     = $clog2(LINE_SIZE);
  localparam int unsigned TAG_WIDTH = DATA_WIDTH - SET_WIDTH - OFF_W - 2;
  localparam int unsigned SETS      = 1 << SET_WIDTH;
  localparam int unsigned WAY_W     = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef logic [LINE_SIZE-1:0][DATA_WIDTH-1:0] line_data_t;
  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic [TAG_WIDTH-1:0] tag;
    line_data_t           data;
  } cache_line_t;

  cache_line_t lines [SETS][WAYS];

  state_t                 state;
  logic [OFF_W-1:0]       cnt;
  logic                   cap_write;
  logic [TAG_WIDTH-1:0]   cap_tag;
  logic [SET_WIDTH-1:0]   cap_set;
  logic [OFF_W-1:0]       cap_off;
  logic [DATA_WIDTH-1:0]  cap_wdata;
  logic [WAY_W-1:0]       victim;
  line_data_t             buffer;

  logic [TAG_WIDTH-1:0]   req_tag;
  logic [SET_WIDTH-1:0]   req_set;
  logic [OFF_W-1:0]       req_off;
  logic                   unused_addr;

  assign req_tag     = address[DATA_WIDTH-1 -: TAG_WIDTH];
  assign req_set     = address[2+OFF_W +: SET_WIDTH];
  assign req_off     = address[2 +: OFF_W];
  assign unused_addr = ^address[1:0];

  logic             hit_any;
  logic [WAY_W-1:0] hit_way;
  logic             inv_found;
  logic [WAY_W-1:0] inv_way;
  logic [WAY_W-1:0] plru_way;
  logic [WAY_W-1:0] victim_sel;
  logic             last_beat;
  logic [OFF_W-1:0] cnt_nxt;
  line_data_t       inst_data;

  always_comb begin
    hit_any   = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (lines[req_set][w].valid && lines[req_set][w].tag == req_tag) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!inv_found && !lines[req_set][w].valid) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
    victim_sel = inv_found ? inv_way : plru_way;
    last_beat  = (cnt == OFF_W'(LINE_SIZE - 1));
    cnt_nxt    = cnt + 1'b1;
    inst_data  = buffer;
    if (cap_write) inst_data[cap_off] = cap_wdata;
  end

  always_comb begin
    case (state)
      IDLE:    stall = req_valid && !hit_any;
      RESPOND: stall = 1'b0;
      default: stall = 1'b1;
    endcase
  end

  logic                 plru_touch_en;
  logic [WAY_W-1:0]     plru_touch_way;
  logic [SET_WIDTH-1:0] plru_set;

  assign plru_touch_en  = (state == IDLE && req_valid && hit_any) || (state == INSTALL);
  assign plru_touch_way = (state == INSTALL) ? victim : hit_way;
  assign plru_set       = (state == IDLE) ? req_set : cap_set;

  l3_plru #(
    .SETS (SETS),
    .WAYS (WAYS),
    .SET_W(SET_WIDTH),
    .WAY_W(WAY_W)
  ) u_plru (
    .clk       (clk),
    .reset     (reset),
    .touch     (plru_touch_en),
    .touch_way (plru_touch_way),
    .set_idx   (plru_set),
    .victim_way(plru_way)
  );

  // The old victim line stays valid until INSTALL, so an abandoned miss leaves no partial line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      cnt            <= '0;
      cap_write      <= 1'b0;
      cap_tag        <= '0;
      cap_set        <= '0;
      cap_off        <= '0;
      cap_wdata      <= '0;
      victim         <= '0;
      buffer         <= '0;
      readData       <= '0;
      rsp_valid      <= 1'b0;
      hit            <= 1'b0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
      for (int unsigned s = 0; s < SETS; s++) begin
        for (int unsigned w = 0; w < WAYS; w++) begin
          lines[s][w].valid <= 1'b0;
          lines[s][w].dirty <= 1'b0;
        end
      end
    end else begin
      case (state)
        IDLE: begin
          rsp_valid <= 1'b0;
          hit       <= 1'b0;
          if (req_valid) begin
            if (hit_any) begin
              rsp_valid <= 1'b1;
              hit       <= 1'b1;
              if (req_write) begin
                lines[req_set][hit_way].data[req_off] <= writeData;
                lines[req_set][hit_way].dirty         <= 1'b1;
                readData                              <= '0;
              end else begin
                readData <= lines[req_set][hit_way].data[req_off];
              end
            end else begin
              cap_write <= req_write;
              cap_tag   <= req_tag;
              cap_set   <= req_set;
              cap_off   <= req_off;
              cap_wdata <= writeData;
              victim    <= victim_sel;
              cnt       <= '0;
              if (lines[req_set][victim_sel].valid && lines[req_set][victim_sel].dirty) begin
                state          <= WRITE_BACK;
                mem_write      <= 1'b1;
                mem_address    <= {lines[req_set][victim_sel].tag, req_set, {OFF_W{1'b0}}, 2'b00};
                mem_write_data <= lines[req_set][victim_sel].data[0];
              end else begin
                state       <= FILL;
                mem_read    <= 1'b1;
                mem_address <= {req_tag, req_set, {OFF_W{1'b0}}, 2'b00};
              end
            end
          end
        end
        WRITE_BACK: begin
          if (mem_ready) begin
            if (last_beat) begin
              mem_write                  <= 1'b0;
              lines[cap_set][victim].dirty <= 1'b0;
              state                      <= FILL;
              mem_read                   <= 1'b1;
              cnt                        <= '0;
              mem_address                <= {cap_tag, cap_set, {OFF_W{1'b0}}, 2'b00};
            end else begin
              cnt            <= cnt_nxt;
              mem_address    <= {lines[cap_set][victim].tag, cap_set, cnt_nxt, 2'b00};
              mem_write_data <= lines[cap_set][victim].data[cnt_nxt];
            end
          end
        end
        FILL: begin
          if (mem_ready) begin
            buffer[cnt] <= mem_read_data;
            if (last_beat) begin
              mem_read <= 1'b0;
              cnt      <= '0;
              state    <= INSTALL;
            end else begin
              cnt         <= cnt_nxt;
              mem_address <= {cap_tag, cap_set, cnt_nxt, 2'b00};
            end
          end
        end
        INSTALL: begin
          lines[cap_set][victim] <= {1'b1, cap_write, cap_tag, inst_data};
          state                  <= RESPOND;
          rsp_valid              <= 1'b1;
          hit                    <= 1'b0;
          readData               <= cap_write ? '0 : buffer[cap_off];
        end
        RESPOND: begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l3_cache_assoc.sv
// Self-checking bench for l3_cache_assoc: directed vector table, corner sequences,
// and random traffic against a transparent-memory + per-set LRU reference model.
module tb_l3_cache_assoc;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] writeData = '0;
  logic [31:0] readData;
  logic        rsp_valid, hit, stall, mem_read, mem_write;
  logic [31:0] mem_address, mem_write_data;
  logic [31:0] mem_read_data = '0;
  logic        mem_ready = 1'b0;

  always #5 clk = ~clk;

  l3_cache_assoc #(
    .DATA_WIDTH(32),
    .SET_WIDTH (6),
    .WAYS      (2),
    .LINE_SIZE (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_write     (req_write),
    .address       (address),
    .writeData     (writeData),
    .readData      (readData),
    .rsp_valid     (rsp_valid),
    .hit           (hit),
    .stall         (stall),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_write_data(mem_write_data),
    .mem_read_data (mem_read_data),
    .mem_ready     (mem_ready)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Backing memory model
  logic [31:0] mem [logic [31:0]];
  int          ready_mode = 0;
  int          fill_beats = 0;
  int          read_cycles = 0;
  int          both_high = 0;
  logic [31:0] wb_addr [$];
  logic [31:0] wb_data [$];

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return init_val(a);
  endfunction

  always @(negedge clk) begin
    case (ready_mode)
      0:       mem_ready = 1'b1;
      1:       mem_ready = ~mem_ready;
      default: mem_ready = 1'($urandom_range(0, 1));
    endcase
    if (mem_read && mem_write) both_high++;
    if (mem_read) read_cycles++;
    if (mem_write && mem_ready) begin
      mem[mem_address] = mem_write_data;
      wb_addr.push_back(mem_address);
      wb_data.push_back(mem_write_data);
    end
    if (mem_read && mem_ready) fill_beats++;
    mem_read_data = mem_rd(mem_address);
  end

  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic h, output logic ok);
    rd = '0;
    h  = 1'b0;
    ok = 1'b0;
    @(posedge clk) #1;
    req_valid = 1'b1;
    req_write = w;
    address   = a;
    writeData = d;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!stall) begin
        if (rsp_valid) begin
          rd = readData; h = hit; ok = 1'b1;
        end else begin
          @(posedge clk) #1;
          req_valid = 1'b0;
          @(negedge clk);
          ok = rsp_valid; rd = readData; h = hit;
        end
        break;
      end
    end
    @(posedge clk) #1;
    req_valid = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_hit;
    int          exp_fill;
    int          exp_wb;
  } vec_t;

  vec_t vecs [10];

  task automatic setv(input int i, input string n, input logic wr, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] er, input logic eh,
                      input int ef, input int ew);
    vecs[i] = '{n, wr, a, d, er, eh, ef, ew};
  endtask

  // Reference: caches are transparent, so reads return the last written value;
  // residency follows true LRU per set (identical to tree PLRU for 2 ways).
  logic [31:0] ref_mem [logic [31:0]];
  logic [19:0] lru_q [64][$];

  initial begin
    logic [31:0] rd;
    logic        h, ok, found;
    int          f0, r0;

    for (int i = 0; i < 16; i++) mem[32'h40 + 32'(4 * i)] = 32'h100 + 32'(i);

    setv(0, "t1_cold",    1'b0, 32'h40,   0,            32'h100,            1'b0, 16, 0);
    setv(1, "t1_reread",  1'b0, 32'h40,   0,            32'h100,            1'b1, 0,  0);
    setv(2, "t2_write",   1'b1, 32'h44,   32'hDEADBEEF, 32'h0,              1'b1, 0,  0);
    setv(3, "t2_read",    1'b0, 32'h44,   0,            32'hDEADBEEF,       1'b1, 0,  0);
    setv(4, "t3_fill_b",  1'b0, 32'h1040, 0,            init_val(32'h1040), 1'b0, 16, 0);
    setv(5, "t3_touch_a", 1'b0, 32'h40,   0,            32'h100,            1'b1, 0,  0);
    setv(6, "t3_miss_c",  1'b0, 32'h2040, 0,            init_val(32'h2040), 1'b0, 16, 0);
    setv(7, "t3_a_stays", 1'b0, 32'h44,   0,            32'hDEADBEEF,       1'b1, 0,  0);
    setv(8, "t3_b_gone",  1'b0, 32'h1048, 0,            init_val(32'h1048), 1'b0, 16, 0);
    setv(9, "t4_dirty",   1'b0, 32'h2040, 0,            init_val(32'h2040), 1'b0, 16, 16);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_readData", readData, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_hit", hit, 0);
    check("rst_mem_read", mem_read, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_mem_address", mem_address, 0);
    check("rst_mem_wdata", mem_write_data, 0);
    check("rst_stall", stall, 0);
    @(negedge clk);
    reset = 1'b1;

    // Tests 1-4 from the vector table
    for (int v = 0; v < 10; v++) begin
      f0 = fill_beats;
      wb_addr.delete();
      wb_data.delete();
      do_req(vecs[v].wr, vecs[v].addr, vecs[v].wdata, rd, h, ok);
      check({vecs[v].name, "_done"}, ok, 1);
      check({vecs[v].name, "_rd"}, rd, vecs[v].exp_rd);
      check({vecs[v].name, "_hit"}, h, vecs[v].exp_hit);
      check({vecs[v].name, "_fill"}, fill_beats - f0, vecs[v].exp_fill);
      check({vecs[v].name, "_wb"}, wb_addr.size(), vecs[v].exp_wb);
    end
    for (int i = 0; i < 16 && i < wb_addr.size(); i++) begin
      check("t4_wb_addr", wb_addr[i], 32'h40 + 32'(4 * i));
      check("t4_wb_data", wb_data[i], (i == 1) ? 32'hDEADBEEF : 32'h100 + 32'(i));
    end

    // Back-to-back hits on resident lines B and C
    @(posedge clk) #1;
    req_valid = 1'b1; req_write = 1'b0; address = 32'h2040;
    @(negedge clk);
    check("b2b_stall_a", stall, 0);
    @(posedge clk) #1;
    address = 32'h1044;
    @(negedge clk);
    check("b2b_stall_b", stall, 0);
    check("b2b_rsp_a", rsp_valid, 1);
    check("b2b_hit_a", hit, 1);
    check("b2b_data_a", readData, init_val(32'h2040));
    @(posedge clk) #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("b2b_rsp_b", rsp_valid, 1);
    check("b2b_data_b", readData, init_val(32'h1044));

    // Test 5: alternating mem_ready during a fill
    ready_mode = 1;
    f0 = fill_beats;
    r0 = read_cycles;
    do_req(1'b0, 32'h3084, 0, rd, h, ok);
    check("t5_done", ok, 1);
    check("t5_rd", rd, init_val(32'h3084));
    check("t5_hit", h, 0);
    check("t5_fill", fill_beats - f0, 16);
    check("t5_slow", 32'(read_cycles - r0 >= 31), 1);
    ready_mode = 0;
    for (int i = 0; i < 16; i++) begin
      do_req(1'b0, 32'h3080 + 32'(4 * i), 0, rd, h, ok);
      check("t5_line_data", rd, init_val(32'h3080 + 32'(4 * i)));
      check("t5_line_hit", h, 1);
    end
    check("both_high_a", both_high, 0);

    // Test 6: reset asserted mid-fill
    f0 = fill_beats;
    found = 1'b0;
    @(posedge clk) #1;
    req_valid = 1'b1; req_write = 1'b0; address = 32'h40C0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk) #1;
      if (fill_beats - f0 == 7) begin
        found = 1'b1;
        break;
      end
    end
    check("t6_reach_beat7", found, 1);
    reset = 1'b0;
    #1;
    check("t6_readData", readData, 0);
    check("t6_rsp_valid", rsp_valid, 0);
    check("t6_hit", hit, 0);
    check("t6_mem_read", mem_read, 0);
    check("t6_mem_write", mem_write, 0);
    check("t6_mem_address", mem_address, 0);
    check("t6_mem_wdata", mem_write_data, 0);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    f0 = fill_beats;
    do_req(1'b0, 32'h40C0, 0, rd, h, ok);
    check("t6_after_done", ok, 1);
    check("t6_after_hit", h, 0);
    check("t6_after_rd", rd, init_val(32'h40C0));
    check("t6_after_fill", fill_beats - f0, 16);

    // Random traffic against the reference model, starting from the post-reset image
    ref_mem = mem;
    for (int s = 0; s < 64; s++) lru_q[s].delete();
    lru_q[3].push_back(20'd4);
    ready_mode = 2;
    for (int n = 0; n < 150; n++) begin
      logic [19:0] t;
      logic [5:0]  s;
      logic [31:0] a, wa, d, er;
      logic        w, eh;
      int          idx;
      t  = 20'($urandom_range(0, 2));
      s  = 6'(5 + $urandom_range(0, 1));
      a  = {t, s, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      wa = {a[31:2], 2'b00};
      w  = ($urandom_range(0, 9) < 4);
      d  = $urandom;
      idx = -1;
      for (int k = 0; k < lru_q[s].size(); k++) if (lru_q[s][k] == t) idx = k;
      eh = (idx >= 0);
      if (eh) lru_q[s].delete(idx);
      else if (lru_q[s].size() == 2) void'(lru_q[s].pop_front());
      lru_q[s].push_back(t);
      er = w ? 32'h0 : (ref_mem.exists(wa) ? ref_mem[wa] : init_val(wa));
      if (w) ref_mem[wa] = d;
      do_req(w, a, d, rd, h, ok);
      check("rand_done", ok, 1);
      check("rand_rd", rd, er);
      check("rand_hit", h, eh);
    end
    check("both_high_b", both_high, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
